ifetch_queue: RTL

Instruction fetch queue between the PC stage and decode. Takes the current fetch address from the PC stage and issues in-order requests to instruction memory over a request/grant/response handshake. Pairs each returned word with its address and buffers it for decode behind a valid/ready interface. Discards queued and in-flight fetches on a redirect (jump or taken branch).

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/ifetch_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, opcodes, instruction field
// positions and the fetch-queue state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int OFF_MSB = 15;
  localparam int OFF_LSB = 0;
  localparam int TGT_MSB = 25;
  localparam int TGT_LSB = 0;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  // One instruction-queue slot: the fetch address paired with its word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop/flush, an occupancy count and a head word
// read straight from storage (forced to zero while empty).
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: state registers take non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates every read so stale words never escape.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order imem requests under a credit limit,
// tags each response with its address and buffers it for decode.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [5:0]  id_op_o,
  output logic [15:0] id_offset_o,
  output logic [25:0] id_target_o
);

  localparam int QCW = $clog2(DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUT + 1);

  fetch_state_e    state_q, state_d;
  logic [OCW-1:0]  drop_cnt_q, drop_cnt_d;
  logic [OCW-1:0]  out_cnt;
  logic [QCW-1:0]  q_cnt;
  logic [XLEN-1:0] tag_head;
  iq_entry_t       iq_in, iq_head;
  logic            credit_ok, grant, rsp_take, id_pop;

  // Credits count both queued and in-flight words, so a response always has a slot.
  assign credit_ok   = (int'(out_cnt) < MAX_OUT) && ((int'(q_cnt) + int'(out_cnt)) < DEPTH);
  assign imem_req_o  = (state_q == RUN) && pc_valid_i && !flush_i && !rst && credit_ok;
  assign imem_addr_o = pc_i;
  assign grant       = imem_req_o && imem_gnt_i;
  assign pc_ready_o  = grant;

  assign rsp_take = imem_rvalid_i && (state_q == RUN) && !flush_i && (out_cnt != '0);
  assign id_pop   = id_valid_o && id_ready_i;
  assign iq_in    = '{pc: tag_head, instr: imem_rdata_i};

  // Occupancy of the tag FIFO is the granted-but-not-returned count.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (grant),
    .data_i  (pc_i),
    .pop_i   (rsp_take),
    .flush_i (flush_i),
    .count_o (out_cnt),
    .head_o  (tag_head)
  );

  sync_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_instr_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_take),
    .data_i  (iq_in),
    .pop_i   (id_pop),
    .flush_i (flush_i),
    .count_o (q_cnt),
    .head_o  (iq_head)
  );

  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      // A response arriving in the flush cycle is itself one of the discarded words.
      if (state_q == RUN) drop_cnt_d = out_cnt - OCW'(imem_rvalid_i && (out_cnt != '0));
      else                drop_cnt_d = drop_cnt_q - OCW'(imem_rvalid_i && (drop_cnt_q != '0));
      state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
    end else if (state_q == DRAIN && imem_rvalid_i) begin
      drop_cnt_d = drop_cnt_q - OCW'(drop_cnt_q != '0);
      if (drop_cnt_d == '0) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign id_valid_o  = (q_cnt != '0);
  assign id_pc_o     = iq_head.pc;
  assign id_instr_o  = iq_head.instr;
  assign id_op_o     = iq_head.instr[OP_MSB:OP_LSB];
  assign id_offset_o = iq_head.instr[OFF_MSB:OFF_LSB];
  assign id_target_o = iq_head.instr[TGT_MSB:TGT_LSB];

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid_i && (state_q == RUN) && (out_cnt == '0)));

endmodule
